// File: rtl/mem_access_unit_pkg.sv
// Shared widths, size/state encodings and request record for the two-slot load/store unit.
package mem_access_unit_pkg;

  localparam int DWIDTH      = 32;
  localparam int AWIDTH_MEM  = 8;
  localparam int AWIDTH_BYTE = AWIDTH_MEM + 2;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SECOND = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic                   load;
    size_e                  size;
    logic                   uns;
    logic [AWIDTH_BYTE-1:0] addr;
    logic [DWIDTH-1:0]      wdata;
  } req_t;

  function automatic logic [AWIDTH_MEM-1:0] word_addr(input logic [AWIDTH_BYTE-1:0] addr);
    return addr[AWIDTH_BYTE-1:2];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle of mem_access_unit; slave is the unit side.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                   lsu_i_valid_1, lsu_i_valid_2;
  logic                   lsu_i_load_1, lsu_i_load_2;
  logic [1:0]             lsu_i_size_1, lsu_i_size_2;
  logic                   lsu_i_unsigned_1, lsu_i_unsigned_2;
  logic [AWIDTH_BYTE-1:0] lsu_i_addr_1, lsu_i_addr_2;
  logic [DWIDTH-1:0]      lsu_i_wdata_1, lsu_i_wdata_2;
  logic                   lsu_o_ready;
  logic                   lsu_o_done_1, lsu_o_done_2;
  logic [DWIDTH-1:0]      lsu_o_rdata_1, lsu_o_rdata_2;
  logic                   lsu_o_misalign_1, lsu_o_misalign_2;
  logic                   lsu_o_ce;
  logic                   lsu_o_wr_en_1, lsu_o_wr_en_2;
  logic [3:0]             lsu_o_mask_1, lsu_o_mask_2;
  logic [AWIDTH_MEM-1:0]  lsu_o_addr_1, lsu_o_addr_2;
  logic [DWIDTH-1:0]      lsu_o_wdata_1, lsu_o_wdata_2;
  logic [DWIDTH-1:0]      lsu_i_mem_rdata_1, lsu_i_mem_rdata_2;

  modport slave (
    input  lsu_i_valid_1, lsu_i_valid_2, lsu_i_load_1, lsu_i_load_2,
           lsu_i_size_1, lsu_i_size_2, lsu_i_unsigned_1, lsu_i_unsigned_2,
           lsu_i_addr_1, lsu_i_addr_2, lsu_i_wdata_1, lsu_i_wdata_2,
           lsu_i_mem_rdata_1, lsu_i_mem_rdata_2,
    output lsu_o_ready, lsu_o_done_1, lsu_o_done_2, lsu_o_rdata_1, lsu_o_rdata_2,
           lsu_o_misalign_1, lsu_o_misalign_2, lsu_o_ce, lsu_o_wr_en_1, lsu_o_wr_en_2,
           lsu_o_mask_1, lsu_o_mask_2, lsu_o_addr_1, lsu_o_addr_2,
           lsu_o_wdata_1, lsu_o_wdata_2
  );

  modport master (
    output lsu_i_valid_1, lsu_i_valid_2, lsu_i_load_1, lsu_i_load_2,
           lsu_i_size_1, lsu_i_size_2, lsu_i_unsigned_1, lsu_i_unsigned_2,
           lsu_i_addr_1, lsu_i_addr_2, lsu_i_wdata_1, lsu_i_wdata_2,
           lsu_i_mem_rdata_1, lsu_i_mem_rdata_2,
    input  lsu_o_ready, lsu_o_done_1, lsu_o_done_2, lsu_o_rdata_1, lsu_o_rdata_2,
           lsu_o_misalign_1, lsu_o_misalign_2, lsu_o_ce, lsu_o_wr_en_1, lsu_o_wr_en_2,
           lsu_o_mask_1, lsu_o_mask_2, lsu_o_addr_1, lsu_o_addr_2,
           lsu_o_wdata_1, lsu_o_wdata_2
  );

endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Per-slot combinational alignment: byte mask, lane-shifted store data,
// misalignment flag and size-truncated, extended load data.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  size_e             size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [DWIDTH-1:0] mem_word,
  output logic [3:0]        mask,
  output logic [DWIDTH-1:0] wdata_sh,
  output logic              misalign,
  output logic [DWIDTH-1:0] load_data
);

  logic [4:0]        bit_off;
  logic [DWIDTH-1:0] word_sh;

  assign bit_off  = {off, 3'b000};
  assign word_sh  = mem_word >> bit_off;
  assign wdata_sh = wdata << bit_off;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    misalign  = 1'b0;
    mask      = 4'b1111;
    load_data = word_sh;
    case (size)
      SZ_BYTE: begin
        mask      = 4'b0001 << off;
        load_data = {{(DWIDTH-8){word_sh[7] & ~uns}}, word_sh[7:0]};
      end
      SZ_HALF: begin
        misalign  = off[0];
        mask      = 4'b0011 << off;
        load_data = {{(DWIDTH-16){word_sh[15] & ~uns}}, word_sh[15:0]};
      end
      default: misalign = |off;
    endcase
    // A zero mask keeps a faulting store from being merged into a forwarded load.
    if (misalign) mask = 4'b0000;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Two-slot load/store unit with same-word conflict splitting.
// Define LSU_FORWARD_EN to forward a slot 1 store into a same-word slot 2 load instead of splitting.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic               lsu_clk,
  input  logic               lsu_rst,
  mem_access_unit_if.slave   bus
);

  state_e            state_q, state_d;
  req_t              req_in [2];
  req_t              req_q [2], req_d [2];
  logic [DWIDTH-1:0] data1_q, data1_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        misalign_q, misalign_d;
  logic [DWIDTH-1:0] rdata_q [2], rdata_d [2];

  logic [3:0]        mask [2];
  logic [DWIDTH-1:0] wdata_sh [2], load_data [2], mem_word [2];
  logic              misalign [2];
  logic [1:0]        drive;
  logic              same_word, both_valid, any_store, fwd, conflict;
  logic [DWIDTH-1:0] merged;

  assign req_in[0] = '{bus.lsu_i_valid_1, bus.lsu_i_load_1, size_e'(bus.lsu_i_size_1),
                       bus.lsu_i_unsigned_1, bus.lsu_i_addr_1, bus.lsu_i_wdata_1};
  assign req_in[1] = '{bus.lsu_i_valid_2, bus.lsu_i_load_2, size_e'(bus.lsu_i_size_2),
                       bus.lsu_i_unsigned_2, bus.lsu_i_addr_2, bus.lsu_i_wdata_2};

  assign same_word  = word_addr(req_q[0].addr) == word_addr(req_q[1].addr);
  assign both_valid = req_q[0].valid & req_q[1].valid;
  assign any_store  = ~req_q[0].load | ~req_q[1].load;
`ifdef LSU_FORWARD_EN
  assign fwd = both_valid & same_word & ~req_q[0].load & req_q[1].load;
`else
  assign fwd = 1'b0;
`endif
  assign conflict = both_valid & same_word & any_store & ~fwd;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    lsu_align u_align (
      .size      (req_q[k].size),
      .uns       (req_q[k].uns),
      .off       (req_q[k].addr[1:0]),
      .wdata     (req_q[k].wdata),
      .mem_word  (mem_word[k]),
      .mask      (mask[k]),
      .wdata_sh  (wdata_sh[k]),
      .misalign  (misalign[k]),
      .load_data (load_data[k])
    );
  end

  // Forwarded slot 2 sees the pre-store word, so slot 1's store lanes are merged in here.
  always_comb begin
    merged = bus.lsu_i_mem_rdata_2;
    for (int b = 0; b < 4; b++)
      if (mask[0][b]) merged[8*b +: 8] = wdata_sh[0][8*b +: 8];
  end

  // Slot 1's read data is overwritten by memory during SECOND, hence the held copy.
  assign mem_word[0] = conflict ? data1_q : bus.lsu_i_mem_rdata_1;
  assign mem_word[1] = fwd ? merged : bus.lsu_i_mem_rdata_2;

  assign drive[0] = (state_q == ST_ACCESS) & req_q[0].valid & ~misalign[0];
  assign drive[1] = (((state_q == ST_ACCESS) & ~conflict) | (state_q == ST_SECOND))
                    & req_q[1].valid & ~misalign[1];

  assign bus.lsu_o_ready      = (state_q == ST_IDLE);
  assign bus.lsu_o_ce         = |drive;
  assign bus.lsu_o_wr_en_1    = drive[0] & ~req_q[0].load;
  assign bus.lsu_o_wr_en_2    = drive[1] & ~req_q[1].load;
  assign bus.lsu_o_mask_1     = drive[0] ? mask[0] : 4'b0000;
  assign bus.lsu_o_mask_2     = drive[1] ? mask[1] : 4'b0000;
  assign bus.lsu_o_addr_1     = drive[0] ? word_addr(req_q[0].addr) : '0;
  assign bus.lsu_o_addr_2     = drive[1] ? word_addr(req_q[1].addr) : '0;
  assign bus.lsu_o_wdata_1    = drive[0] ? wdata_sh[0] : '0;
  assign bus.lsu_o_wdata_2    = drive[1] ? wdata_sh[1] : '0;
  assign bus.lsu_o_done_1     = done_q[0];
  assign bus.lsu_o_done_2     = done_q[1];
  assign bus.lsu_o_rdata_1    = rdata_q[0];
  assign bus.lsu_o_rdata_2    = rdata_q[1];
  assign bus.lsu_o_misalign_1 = misalign_q[0];
  assign bus.lsu_o_misalign_2 = misalign_q[1];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data1_d    = data1_q;
    done_d     = 2'b00;
    misalign_d = misalign_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in[0].valid | req_in[1].valid) begin
          req_d   = req_in;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = conflict ? ST_SECOND : ST_RESP;
      ST_SECOND: begin
        data1_d = bus.lsu_i_mem_rdata_1;
        state_d = ST_RESP;
      end
      default: begin
        for (int k = 0; k < 2; k++) begin
          if (req_q[k].valid) begin
            done_d[k]     = 1'b1;
            misalign_d[k] = misalign[k];
            rdata_d[k]    = (req_q[k].load && !misalign[k]) ? load_data[k] : '0;
          end
          req_d[k] = '0;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      state_q    <= ST_IDLE;
      data1_q    <= '0;
      done_q     <= 2'b00;
      misalign_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        req_q[k]   <= '0;
        rdata_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      data1_q    <= data1_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a two-port byte-masked memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

`ifdef LSU_FORWARD_EN
  localparam int FWD_LAT = 2;
  localparam int FWD_CE  = 1;
`else
  localparam int FWD_LAT = 3;
  localparam int FWD_CE  = 2;
`endif
  localparam int NV = 17;

  typedef struct {
    logic v1; logic l1; logic [1:0] sz1; logic u1; logic [AWIDTH_BYTE-1:0] a1; logic [31:0] w1;
    logic v2; logic l2; logic [1:0] sz2; logic u2; logic [AWIDTH_BYTE-1:0] a2; logic [31:0] w2;
    int lat; int ce_n; logic [31:0] rd1; logic [31:0] rd2; logic mis1; logic mis2;
    logic [3:0] m1; logic [3:0] m2; logic [31:0] wd1; logic [31:0] wd2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ce_cnt = 0;
  int   done_cnt = 0;
  logic [3:0]  lm1, lm2;
  logic [31:0] lwd1, lwd2;
  logic [31:0] mem [256];
  vec_t vecs [NV];

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .lsu_clk (clk),
    .lsu_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data registered one cycle after the address, read-before-write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[6] <= 32'h12345678;
      bus.lsu_i_mem_rdata_1 <= 32'h0;
      bus.lsu_i_mem_rdata_2 <= 32'h0;
    end else if (bus.lsu_o_ce) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.lsu_o_wr_en_1 && bus.lsu_o_mask_1[b])
          mem[bus.lsu_o_addr_1][8*b +: 8] <= bus.lsu_o_wdata_1[8*b +: 8];
        if (bus.lsu_o_wr_en_2 && bus.lsu_o_mask_2[b])
          mem[bus.lsu_o_addr_2][8*b +: 8] <= bus.lsu_o_wdata_2[8*b +: 8];
      end
      bus.lsu_i_mem_rdata_1 <= mem[bus.lsu_o_addr_1];
      bus.lsu_i_mem_rdata_2 <= mem[bus.lsu_o_addr_2];
    end
  end

  always @(negedge clk) begin
    if (bus.lsu_o_ce) ce_cnt++;
    if (bus.lsu_o_mask_1 != 4'b0) begin lm1 = bus.lsu_o_mask_1; lwd1 = bus.lsu_o_wdata_1; end
    if (bus.lsu_o_mask_2 != 4'b0) begin lm2 = bus.lsu_o_mask_2; lwd2 = bus.lsu_o_wdata_2; end
    if (bus.lsu_o_done_1 || bus.lsu_o_done_2) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.lsu_i_valid_1 = v.v1; bus.lsu_i_load_1 = v.l1; bus.lsu_i_size_1 = v.sz1;
    bus.lsu_i_unsigned_1 = v.u1; bus.lsu_i_addr_1 = v.a1; bus.lsu_i_wdata_1 = v.w1;
    bus.lsu_i_valid_2 = v.v2; bus.lsu_i_load_2 = v.l2; bus.lsu_i_size_2 = v.sz2;
    bus.lsu_i_unsigned_2 = v.u2; bus.lsu_i_addr_2 = v.a2; bus.lsu_i_wdata_2 = v.w2;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    string t;
    t = $sformatf("v%0d", idx);
    drive(v);
    @(posedge clk); #1;
    bus.lsu_i_valid_1 = 1'b0;
    bus.lsu_i_valid_2 = 1'b0;
    check({t, "_ready_busy"}, bus.lsu_o_ready, 0);
    ce_cnt = 0; lm1 = '0; lm2 = '0; lwd1 = '0; lwd2 = '0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(bus.lsu_o_done_1 || bus.lsu_o_done_2) && lat < 8);
    check({t, "_latency"}, lat, v.lat);
    check({t, "_done1"}, bus.lsu_o_done_1, v.v1);
    check({t, "_done2"}, bus.lsu_o_done_2, v.v2);
    check({t, "_rdata1"}, bus.lsu_o_rdata_1, v.rd1);
    check({t, "_rdata2"}, bus.lsu_o_rdata_2, v.rd2);
    if (v.v1) check({t, "_misalign1"}, bus.lsu_o_misalign_1, v.mis1);
    if (v.v2) check({t, "_misalign2"}, bus.lsu_o_misalign_2, v.mis2);
    check({t, "_ce_cycles"}, ce_cnt, v.ce_n);
    check({t, "_mask1"}, lm1, v.m1);
    check({t, "_mask2"}, lm2, v.m2);
    check({t, "_wdata1"}, lwd1, v.wd1);
    check({t, "_wdata2"}, lwd2, v.wd2);
    @(posedge clk); #1;
    check({t, "_done_pulse"}, {bus.lsu_o_done_1, bus.lsu_o_done_2}, 0);
  endtask

  initial begin
    // Fields: slot1 {v,load,size,uns,addr,wdata}, slot2 {...}, latency, ce cycles,
    //         rdata1, rdata2, misalign1, misalign2, mask1, mask2, wdata1, wdata2
    vecs[0]  = '{1,0,2,0,12,32'hAABBCCDD, 0,0,0,0,0,0, 2,1, 32'h0,32'h0, 0,0, 4'hF,4'h0, 32'hAABBCCDD,0};
    vecs[1]  = '{1,1,2,0,12,0, 0,0,0,0,0,0, 2,1, 32'hAABBCCDD,32'h0, 0,0, 4'hF,4'h0, 0,0};
    vecs[2]  = '{1,1,0,0,13,0, 0,0,0,0,0,0, 2,1, 32'hFFFFFFCC,32'h0, 0,0, 4'h2,4'h0, 0,0};
    vecs[3]  = '{1,1,0,1,13,0, 0,0,0,0,0,0, 2,1, 32'h000000CC,32'h0, 0,0, 4'h2,4'h0, 0,0};
    vecs[4]  = '{0,0,0,0,0,0, 1,0,1,0,18,32'h0000EEFF, 2,1, 32'h000000CC,32'h0, 0,0, 4'h0,4'hC, 0,32'hEEFF0000};
    vecs[5]  = '{0,0,0,0,0,0, 1,1,1,1,18,0, 2,1, 32'h000000CC,32'h0000EEFF, 0,0, 4'h0,4'hC, 0,0};
    vecs[6]  = '{0,0,0,0,0,0, 1,1,1,0,18,0, 2,1, 32'h000000CC,32'hFFFFEEFF, 0,0, 4'h0,4'hC, 0,0};
    vecs[7]  = '{1,1,2,0,14,0, 0,0,0,0,0,0, 2,0, 32'h0,32'hFFFFEEFF, 1,0, 4'h0,4'h0, 0,0};
    vecs[8]  = '{1,0,2,0,20,32'h11223344, 1,0,2,0,20,32'h55667788, 3,2, 32'h0,32'h0, 0,0,
                 4'hF,4'hF, 32'h11223344,32'h55667788};
    vecs[9]  = '{1,1,2,0,20,0, 0,0,0,0,0,0, 2,1, 32'h55667788,32'h0, 0,0, 4'hF,4'h0, 0,0};
    vecs[10] = '{1,1,0,0,21,0, 1,1,1,0,22,0, 2,1, 32'h00000077,32'h00005566, 0,0, 4'h2,4'hC, 0,0};
    vecs[11] = '{1,0,0,0,24,32'h99, 1,1,2,0,24,0, FWD_LAT,FWD_CE, 32'h0,32'h12345699, 0,0,
                 4'h1,4'hF, 32'h00000099,0};
    vecs[12] = '{1,0,0,0,31,32'h5A, 1,1,2,0,32,0, 2,1, 32'h0,32'h0, 0,0, 4'h8,4'hF, 32'h5A000000,0};
    vecs[13] = '{1,1,2,0,28,0, 0,0,0,0,0,0, 2,1, 32'h5A000000,32'h0, 0,0, 4'hF,4'h0, 0,0};
    vecs[14] = '{1,1,0,0,31,0, 1,1,0,1,25,0, 2,1, 32'h0000005A,32'h00000056, 0,0, 4'h8,4'h2, 0,0};
    vecs[15] = '{0,0,0,0,0,0, 1,1,3,0,12,0, 2,1, 32'h0000005A,32'hAABBCCDD, 0,0, 4'h0,4'hF, 0,0};
    vecs[16] = '{0,0,0,0,0,0, 1,0,1,0,19,32'h1234, 2,0, 32'h0000005A,32'h0, 0,1, 4'h0,4'h0, 0,0};

    drive('{default: 0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", bus.lsu_o_ready, 1);
    check("reset_ce", bus.lsu_o_ce, 0);
    check("reset_done", {bus.lsu_o_done_1, bus.lsu_o_done_2}, 0);
    check("reset_rdata1", bus.lsu_o_rdata_1, 0);
    check("reset_rdata2", bus.lsu_o_rdata_2, 0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while the request is in ACCESS: discarded, no completion.
    drive(vecs[1]);
    @(posedge clk); #1;
    bus.lsu_i_valid_1 = 1'b0;
    check("rst_mid_busy", bus.lsu_o_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", bus.lsu_o_ready, 1);
    check("rst_mid_done", {bus.lsu_o_done_1, bus.lsu_o_done_2}, 0);
    check("rst_mid_rdata1", bus.lsu_o_rdata_1, 0);
    check("rst_mid_ce", bus.lsu_o_ce, 0);
    done_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", bus.lsu_o_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
